core_seq: RTL and testbench
===========================

Name: core_seq

Overview:
- Parametrised multicycle instruction sequencer; successor to the fixed-format core control FSM.
- Owns PC, fetch handshake, decode latching, dispatch to NUM_UNITS execution units and register write-back.
- Unit datapaths (alu, memory, branch, ...) and the decoder sit outside and connect through generic per-unit start/done/result buses.
- New versus the previous generation: configurable unit count, per-instruction single- or multi-cycle dispatch, exec watchdog, halt request, trap state.

Parameters:
WORD_W, 32, data word width
ADDR_W, 32, PC width
INST_W, 32, instruction width
REG_A_W, 5, register address width
NUM_UNITS, 5, number of execution units (>=2)
RESET_PC, 0, PC value after reset
PC_STEP, 4, sequential PC increment
WAIT_MAX, 255, max EXECUTE_WAIT cycles before trap (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
stat  out  8  one-hot current state
halt_req  in  1  request stop at instruction boundary
fetch_order  out  1  one-cycle fetch request pulse
fetch_pc  out  ADDR_W  address for fetch (current pc)
fetched  in  1  fetch complete, inst_in valid
inst_in  in  INST_W  fetched instruction
inst_fd  out  INST_W  latched instruction to decoder
pc_fd  out  ADDR_W  PC of latched instruction
dec_unit  in  UNIT_W  selected unit index, UNIT_W=$clog2(NUM_UNITS)
dec_multi  in  1  unit is multi-cycle
dec_wb  in  1  instruction writes rd
dec_a_rd  in  REG_A_W  destination register
unit_start  out  NUM_UNITS  one-hot start pulse
unit_done  in  NUM_UNITS  per-unit completion
unit_result  in  NUM_UNITS*WORD_W  packed results, unit i at [i*WORD_W +: WORD_W]
unit_redirect  in  NUM_UNITS  unit requests non-sequential PC
unit_next_pc  in  NUM_UNITS*ADDR_W  packed redirect targets
reg_flag  out  1  register write enable
reg_a_rd  out  REG_A_W  write address
reg_d_rd  out  WORD_W  write data
trap  out  1  sticky error flag
trap_cause  out  2  0 none, 1 bad unit index, 2 watchdog
cycle_cnt  out  64  cycle counter (see Optional Feature)
instret_cnt  out  64  retired-instruction counter

Behaviour:
- Reset (async): state=FETCH, pc=RESET_PC; all other outputs and registers 0.
- States: FETCH, FETCH_WAIT, DECODE, EXECUTE, EXECUTE_WAIT, WRITE, HALT, TRAP.
- FETCH: fetch_order=1 for exactly one cycle; reg_flag cleared; -> FETCH_WAIT.
- FETCH_WAIT: fetch_order=0; on fetched, latch inst_fd<=inst_in and pc_fd<=pc; -> DECODE. A fetched pulse seen in any other state is ignored.
- DECODE: one cycle; latch dec_*.
  - dec_unit>=NUM_UNITS -> TRAP, cause 1.
  - Otherwise -> EXECUTE.
- EXECUTE: unit_start[u]=1 for one cycle.
  - Single-cycle (!multi): sample result/redirect of unit u this cycle; -> WRITE.
  - Multi-cycle: clear wait counter; -> EXECUTE_WAIT.
- EXECUTE_WAIT:
  - unit_done[u] sampled from the cycle after start onward; done from non-selected units is ignored.
  - On done: capture result/redirect; -> WRITE.
  - Otherwise increment the counter; counter==WAIT_MAX with no done -> TRAP, cause 2.
  - Done arriving on the cycle the counter reaches WAIT_MAX wins (-> WRITE).
- WRITE:
  - reg_flag=1 iff dec_wb && dec_a_rd!=0; reg_a_rd/reg_d_rd hold the captured values. reg_flag drops in the next FETCH.
  - pc<=redirect ? next_pc : pc+PC_STEP, modulo 2^ADDR_W.
  - Next state: HALT if halt_req, else FETCH.
- HALT: no requests issued; -> FETCH when halt_req=0.
- halt_req outside WRITE never aborts an instruction in flight.
- TRAP: trap=1, terminal; only rst exits. No starts, no writes, pc frozen.
- Latency: single-cycle instruction = 5 cycles + fetch wait; multi-cycle adds unit latency + 1.

Optional Feature:
Macro CORE_SEQ_PERF_CNT_EN.
- Defined: cycle_cnt increments every cycle out of reset (wraps at 2^64); instret_cnt increments on each WRITE cycle; both are frozen in TRAP.
- Undefined: both outputs tied to 0 and no counter flops.

Decomposition:
- Shared package/include: state one-hot constants, STATE_NUM=8, trap cause codes, default widths.
- One natural sub-module, core_seq_wdog: wait counter with clear/enable/expired.

Test Plan:
- Single-cycle unit 0: fetched after 2 cycles, inst 0x00000013, dec_wb=1, rd=5, result 0x1234 -> reg_flag pulse writes x5=0x1234; pc 0->4; instret_cnt=1.
- Multi-cycle unit 1: done 3 cycles after start, result 0xDEADBEEF, rd=7 -> x7 written; start pulse exactly 1 cycle; done on unit 2 during the wait is ignored.
- Redirect: unit 2 with redirect=1, next_pc=0x100, dec_wb=0 -> no write, pc=0x100, next fetch_pc=0x100.
- Watchdog: WAIT_MAX=4, done never asserted -> TRAP, trap_cause=2, no further fetch_order; rst restores pc=RESET_PC.
- Bad unit: dec_unit=7 with NUM_UNITS=5 -> TRAP, cause 1, unit_start stays 0.
- halt_req held across WRITE -> HALT, no fetch; release -> FETCH at the next pc. rst asserted mid EXECUTE_WAIT -> immediate FETCH state, all outputs 0.

Source files
------------

// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared state encoding, trap causes and default widths for core_seq
package core_seq_pkg;
    localparam int STATE_NUM     = 8;
    localparam int DEF_WORD_W    = 32;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_INST_W    = 32;
    localparam int DEF_REG_A_W   = 5;
    localparam int DEF_NUM_UNITS = 5;
    localparam int DEF_WAIT_MAX  = 255;
    typedef enum logic [STATE_NUM-1:0] {
        S_FETCH        = 8'h01,
        S_FETCH_WAIT   = 8'h02,
        S_DECODE       = 8'h04,
        S_EXECUTE      = 8'h08,
        S_EXECUTE_WAIT = 8'h10,
        S_WRITE        = 8'h20,
        S_HALT         = 8'h40,
        S_TRAP         = 8'h80
    } state_e;
    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_UNIT = 2'd1,
        CAUSE_WDOG = 2'd2
    } cause_e;
endpackage

// File: rtl/core_seq_wdog.sv
// core_seq_wdog: watchdog counter bounding the wait for a multi-cycle unit
// Ports: clk; rst (async, active-high); clr restarts the count; en counts one
//        idle wait cycle; expired flags that the current idle cycle is the MAX-th.
module core_seq_wdog #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(MAX + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign expired = cnt_q == CNT_W'(MAX - 1);
endmodule

// File: rtl/core_seq.sv
// core_seq: multicycle instruction sequencer (fetch, decode latch, unit dispatch, write-back)
// Ports: clk/rst (async, active-high); stat one-hot state; halt_req stop at boundary;
//        fetch_order/fetch_pc/fetched/inst_in fetch handshake; inst_fd/pc_fd to decoder;
//        dec_* decoded fields; unit_start/unit_done/unit_result/unit_redirect/unit_next_pc
//        per-unit buses; reg_flag/reg_a_rd/reg_d_rd write-back; trap/trap_cause error;
//        cycle_cnt/instret_cnt performance counters.
// Optional: define CORE_SEQ_PERF_CNT_EN to build the performance counters (else tied to 0).
module core_seq
    import core_seq_pkg::*;
#(
    parameter int                WORD_W    = DEF_WORD_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                INST_W    = DEF_INST_W,
    parameter int                REG_A_W   = DEF_REG_A_W,
    parameter int                NUM_UNITS = DEF_NUM_UNITS,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                PC_STEP   = 4,
    parameter int                WAIT_MAX  = DEF_WAIT_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [STATE_NUM-1:0]          stat,
    input  logic                          halt_req,
    output logic                          fetch_order,
    output logic [ADDR_W-1:0]             fetch_pc,
    input  logic                          fetched,
    input  logic [INST_W-1:0]             inst_in,
    output logic [INST_W-1:0]             inst_fd,
    output logic [ADDR_W-1:0]             pc_fd,
    input  logic [$clog2(NUM_UNITS)-1:0]  dec_unit,
    input  logic                          dec_multi,
    input  logic                          dec_wb,
    input  logic [REG_A_W-1:0]            dec_a_rd,
    output logic [NUM_UNITS-1:0]          unit_start,
    input  logic [NUM_UNITS-1:0]          unit_done,
    input  logic [NUM_UNITS*WORD_W-1:0]   unit_result,
    input  logic [NUM_UNITS-1:0]          unit_redirect,
    input  logic [NUM_UNITS*ADDR_W-1:0]   unit_next_pc,
    output logic                          reg_flag,
    output logic [REG_A_W-1:0]            reg_a_rd,
    output logic [WORD_W-1:0]             reg_d_rd,
    output logic                          trap,
    output logic [1:0]                    trap_cause,
    output logic [63:0]                   cycle_cnt,
    output logic [63:0]                   instret_cnt
);
    localparam int UNIT_W = $clog2(NUM_UNITS);
    state_e               state_q, state_d;
    cause_e               cause_q, cause_d;
    logic [ADDR_W-1:0]    pc_q, pc_d, pc_fd_q, pc_fd_d, npc_q, npc_d;
    logic [INST_W-1:0]    inst_q, inst_d;
    logic [UNIT_W-1:0]    unit_q, unit_d;
    logic [REG_A_W-1:0]   rd_q, rd_d;
    logic [WORD_W-1:0]    res_q, res_d;
    logic [NUM_UNITS-1:0] unit_start_q, unit_start_d;
    logic multi_q, multi_d, wb_q, wb_d, redir_q, redir_d;
    logic fetch_order_q, fetch_order_d, reg_flag_q, reg_flag_d;
    logic sel_done, capture, wd_clr, wd_en, wd_expired;

    core_seq_wdog #(.MAX(WAIT_MAX)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // Done is only looked at in EXECUTE_WAIT, so a done raised in the start cycle is ignored.
    assign sel_done = unit_done[unit_q];
    assign capture  = (state_q == S_EXECUTE && !multi_q) || (state_q == S_EXECUTE_WAIT && sel_done);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        pc_fd_d = pc_fd_q;
        inst_d  = inst_q;
        unit_d  = unit_q;
        multi_d = multi_q;
        wb_d    = wb_q;
        rd_d    = rd_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        case (state_q)
            // The first FETCH after reset has no pulse yet, so it lingers one cycle to issue it.
            S_FETCH: state_d = fetch_order_q ? S_FETCH_WAIT : S_FETCH;
            S_FETCH_WAIT: begin
                if (fetched) begin
                    inst_d  = inst_in;
                    pc_fd_d = pc_q;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unit_d  = dec_unit;
                multi_d = dec_multi;
                wb_d    = dec_wb;
                rd_d    = dec_a_rd;
                state_d = int'(dec_unit) >= NUM_UNITS ? S_TRAP : S_EXECUTE;
                cause_d = int'(dec_unit) >= NUM_UNITS ? CAUSE_UNIT : cause_q;
            end
            S_EXECUTE: begin
                wd_clr  = multi_q;
                state_d = multi_q ? S_EXECUTE_WAIT : S_WRITE;
            end
            S_EXECUTE_WAIT: begin
                wd_en   = !sel_done;
                state_d = sel_done ? S_WRITE : wd_expired ? S_TRAP : S_EXECUTE_WAIT;
                cause_d = !sel_done && wd_expired ? CAUSE_WDOG : cause_q;
            end
            S_WRITE: begin
                pc_d    = redir_q ? npc_q : pc_q + ADDR_W'(PC_STEP);
                state_d = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: state_d = halt_req ? S_HALT : S_FETCH;
            default: ;
        endcase
        res_d         = capture ? unit_result[int'(unit_q)*WORD_W +: WORD_W] : res_q;
        redir_d       = capture ? unit_redirect[unit_q] : redir_q;
        npc_d         = capture ? unit_next_pc[int'(unit_q)*ADDR_W +: ADDR_W] : npc_q;
        fetch_order_d = state_d == S_FETCH;
        unit_start_d  = state_d == S_EXECUTE ? NUM_UNITS'(1) << unit_d : '0;
        reg_flag_d    = state_d == S_WRITE ? wb_q && |rd_q : state_d == S_FETCH ? 1'b0 : reg_flag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            cause_q       <= CAUSE_NONE;
            pc_q          <= RESET_PC;
            pc_fd_q       <= '0;
            npc_q         <= '0;
            inst_q        <= '0;
            unit_q        <= '0;
            rd_q          <= '0;
            res_q         <= '0;
            unit_start_q  <= '0;
            multi_q       <= 1'b0;
            wb_q          <= 1'b0;
            redir_q       <= 1'b0;
            fetch_order_q <= 1'b0;
            reg_flag_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            pc_q          <= pc_d;
            pc_fd_q       <= pc_fd_d;
            npc_q         <= npc_d;
            inst_q        <= inst_d;
            unit_q        <= unit_d;
            rd_q          <= rd_d;
            res_q         <= res_d;
            unit_start_q  <= unit_start_d;
            multi_q       <= multi_d;
            wb_q          <= wb_d;
            redir_q       <= redir_d;
            fetch_order_q <= fetch_order_d;
            reg_flag_q    <= reg_flag_d;
        end
    end

`ifdef CORE_SEQ_PERF_CNT_EN
    logic [63:0] cyc_q, cyc_d, ret_q, ret_d;
    always_comb begin
        cyc_d = state_q == S_TRAP ? cyc_q : cyc_q + 64'd1;
        ret_d = state_q == S_WRITE ? ret_q + 64'd1 : ret_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end
    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

    assign stat        = state_q;
    assign fetch_order = fetch_order_q;
    assign fetch_pc    = pc_q;
    assign inst_fd     = inst_q;
    assign pc_fd       = pc_fd_q;
    assign unit_start  = unit_start_q;
    assign reg_flag    = reg_flag_q;
    assign reg_a_rd    = rd_q;
    assign reg_d_rd    = res_q;
    assign trap        = state_q == S_TRAP;
    assign trap_cause  = cause_q;
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: randomized self-checking bench for core_seq against a per-instruction model
module tb_core_seq;
    localparam int NU = 5;
    localparam int WM = 4;
    localparam int AW = 32;
    localparam int WW = 32;
    localparam logic [AW-1:0] RESET_PC = '0;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     stat;
    logic           halt_req = 1'b0;
    logic           fetch_order;
    logic [AW-1:0]  fetch_pc;
    logic           fetched = 1'b0;
    logic [31:0]    inst_in = '0;
    logic [31:0]    inst_fd;
    logic [AW-1:0]  pc_fd;
    logic [2:0]     dec_unit = '0;
    logic           dec_multi = 1'b0;
    logic           dec_wb = 1'b0;
    logic [4:0]     dec_a_rd = '0;
    logic [NU-1:0]  unit_start;
    logic [NU-1:0]  unit_done = '0;
    logic [NU*WW-1:0] unit_result = '0;
    logic [NU-1:0]  unit_redirect = '0;
    logic [NU*AW-1:0] unit_next_pc = '0;
    logic           reg_flag;
    logic [4:0]     reg_a_rd;
    logic [WW-1:0]  reg_d_rd;
    logic           trap;
    logic [1:0]     trap_cause;
    logic [63:0]    cycle_cnt;
    logic [63:0]    instret_cnt;

    int n_chk = 0;
    int n_pass = 0;
    logic [AW-1:0] m_pc;
    longint unsigned m_ret;

    core_seq #(.NUM_UNITS(NU), .WAIT_MAX(WM), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stat(stat), .halt_req(halt_req),
        .fetch_order(fetch_order), .fetch_pc(fetch_pc), .fetched(fetched), .inst_in(inst_in),
        .inst_fd(inst_fd), .pc_fd(pc_fd), .dec_unit(dec_unit), .dec_multi(dec_multi),
        .dec_wb(dec_wb), .dec_a_rd(dec_a_rd), .unit_start(unit_start), .unit_done(unit_done),
        .unit_result(unit_result), .unit_redirect(unit_redirect), .unit_next_pc(unit_next_pc),
        .reg_flag(reg_flag), .reg_a_rd(reg_a_rd), .reg_d_rd(reg_d_rd), .trap(trap),
        .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic report();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        halt_req = 1'b0;
        fetched = 1'b0;
        unit_done = '0;
        #1;
        check("rst_stat", stat, 8'h01);
        check("rst_fetch", fetch_order, 0);
        check("rst_pc", fetch_pc, RESET_PC);
        check("rst_trap", {trap, trap_cause}, 0);
        check("rst_start", unit_start, 0);
        check("rst_reg", {reg_flag, reg_a_rd, reg_d_rd}, 0);
        check("rst_fd", {inst_fd, pc_fd}, 0);
        check("rst_cnt", cycle_cnt | instret_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        m_pc = RESET_PC;
        m_ret = 0;
    endtask

    task automatic wait_fetch();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = fetch_order;
        end
        check("fetch_seen", ok, 1);
        if (!ok) report();
        check("fetch_pc", fetch_pc, m_pc);
`ifdef CORE_SEQ_PERF_CNT_EN
        check("instret", instret_cnt, m_ret);
`else
        check("perf_off", cycle_cnt | instret_cnt, 0);
`endif
    endtask

    task automatic check_trap(input int cause);
        bit quiet;
        logic [63:0] cyc0;
        quiet = 1'b1;
        check("trap_flag", trap, 1);
        check("trap_cause", trap_cause, cause);
        check("trap_stat", stat, 8'h80);
        cyc0 = cycle_cnt;
        repeat (6) begin
            @(negedge clk);
            if (fetch_order || unit_start != '0 || reg_flag) quiet = 1'b0;
        end
        check("trap_quiet", quiet, 1);
        check("trap_pc", fetch_pc, m_pc);
        check("trap_cyc_frozen", cycle_cnt, cyc0);
        do_reset();
    endtask

    // One instruction from fetch to write-back; lat is the wait cycle carrying done
    // (outside 1..WM means no done in time), abort resets the core in that wait cycle.
    task automatic do_instr(input int u, input bit multi, input bit wb, input int rd,
                            input logic [31:0] res, input bit redir, input logic [31:0] npc,
                            input int fdly, input int lat, input int halt_cyc, input bit early,
                            input int abort);
        logic [31:0] inst;
        logic [NU-1:0] oh;
        bit good, wr;
        inst = $urandom;
        oh = NU'(1) << u;
        good = lat >= 1 && lat <= WM;
        wr = wb && rd != 0;
        wait_fetch();
        @(negedge clk);
        check("fetch_pulse", fetch_order, 0);
        repeat (fdly - 1) @(negedge clk);
        fetched = 1'b1;
        inst_in = inst;
        halt_req = halt_cyc > 0;
        dec_unit = 3'(u);
        dec_multi = multi;
        dec_wb = wb;
        dec_a_rd = 5'(rd);
        for (int i = 0; i < NU; i++) begin
            unit_result[i*WW +: WW] = i == u ? res : $urandom;
            unit_redirect[i] = i == u ? redir : 1'($urandom);
            unit_next_pc[i*AW +: AW] = i == u ? npc : $urandom;
        end
        @(negedge clk);
        fetched = 1'b0;
        inst_in = $urandom;
        check("dec_stat", stat, 8'h04);
        check("inst_fd", inst_fd, inst);
        check("pc_fd", pc_fd, m_pc);
        @(negedge clk);
        if (u >= NU) begin
            check("bad_start", unit_start, 0);
            check_trap(1);
            return;
        end
        check("start", unit_start, oh);
        if (multi) begin
            if (early) unit_done = oh;
            for (int w = 1; w <= (good ? lat : WM); w++) begin
                @(negedge clk);
                if (abort == w) begin
                    do_reset();
                    return;
                end
                if (w == 1) check("start_pulse", unit_start, 0);
                unit_done = w == lat ? oh : w == 1 ? ~oh : NU'($urandom) & ~oh;
            end
            @(negedge clk);
            unit_done = '0;
            if (!good) begin
                check_trap(2);
                return;
            end
        end else begin
            @(negedge clk);
        end
        check("wr_stat", stat, 8'h20);
        check("wr_flag", reg_flag, wr);
        if (wr) begin
            check("wr_addr", reg_a_rd, rd);
            check("wr_data", reg_d_rd, res);
        end
        m_pc = redir ? npc : m_pc + 32'd4;
        m_ret++;
        for (int h = 0; h < halt_cyc; h++) begin
            @(negedge clk);
            check("halt_stat", stat, 8'h40);
            check("halt_nofetch", fetch_order, 0);
        end
        halt_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int u, lat, hc;
        bit mc;
        @(negedge clk);
        do_reset();
        do_instr(0, 0, 1, 5, 32'h1234, 0, 0, 2, 0, 0, 0, 0);
        do_instr(1, 1, 1, 7, 32'hDEADBEEF, 0, 0, 1, 3, 0, 0, 0);
        do_instr(2, 0, 0, 9, 32'h5555, 1, 32'h100, 1, 0, 0, 0, 0);
        do_instr(3, 1, 1, 4, 32'h77, 0, 0, 3, WM, 0, 1, 0);
        do_instr(4, 0, 1, 0, 32'h99, 0, 0, 1, 0, 0, 0, 0);
        do_instr(4, 0, 1, 3, 32'hABCD, 0, 0, 1, 0, 3, 0, 0);
        do_instr(3, 1, 1, 2, 32'h1, 0, 0, 1, 0, 0, 0, 0);
        do_instr(7, 0, 1, 2, 32'h1, 0, 0, 1, 0, 0, 0, 0);
        do_instr(1, 1, 1, 6, 32'h2, 0, 0, 1, 0, 0, 0, 2);
        for (int n = 0; n < 200; n++) begin
            u = $urandom_range(0, 19) == 0 ? $urandom_range(NU, 7) : $urandom_range(0, NU - 1);
            mc = 1'($urandom_range(0, 1));
            lat = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) == 0 ? 0 : WM + 1) : $urandom_range(1, WM);
            hc = $urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0;
            do_instr(u, mc, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom,
                     1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 4), lat, hc,
                     1'($urandom_range(0, 1)), 0);
        end
        report();
    end
endmodule
